// File: rtl/gift_pkg.sv
// gift_pkg: shared widths and controller state encoding for the GIFT-128 decryption stream interface.
package gift_pkg;
    localparam int GIFT_BLK_W    = 128;
    localparam int STREAM_W      = 32;
    localparam int WORDS_PER_BLK = 4;
    typedef enum logic [2:0] {LOAD, KEY, DATA, WAIT_HI, WAIT_LO, OUT} state_t;
endpackage

// File: rtl/gift_word_packer.sv
// gift_word_packer: places four 32-bit words into a 128-bit register, first word at the top.
module gift_word_packer
    import gift_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic                  i_clr,
    input  logic [STREAM_W-1:0]   i_data,
    output logic [GIFT_BLK_W-1:0] o_blk,
    output logic                  o_done
);
    logic [1:0]            r_cnt;
    logic [GIFT_BLK_W-1:0] r_blk;

    // Word n lands at bit offset 32*(3-n), i.e. {~n, 5'b0}.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_blk <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_we) begin
            r_blk[{~r_cnt, 5'd0} +: STREAM_W] <= i_data;
            r_cnt                              <= r_cnt + 1'b1;
        end
    end

    assign o_blk  = r_blk;
    assign o_done = i_we & (&r_cnt);
endmodule

// File: rtl/gift_dec_stream_if.sv
// gift_dec_stream_if: 32-bit stream front/back end for the one-round GIFT-128 decryption core.
// Optional busy watchdog enabled by defining GIFT_DEC_STREAM_WDOG_EN.
module gift_dec_stream_if
    import gift_pkg::*;
#(
    parameter int BUSY_RISE_WAIT = 4,
    parameter int WDOG_CYCLES    = 64
) (
    input  logic                  inClk,
    input  logic                  inRst,
    input  logic                  inWordValid,
    input  logic                  inWordSel,
    input  logic [STREAM_W-1:0]   inWordData,
    output logic                  outWordReady,
    output logic                  outKeyWr,
    output logic [GIFT_BLK_W-1:0] outKeyData,
    output logic                  outDataWr,
    output logic [GIFT_BLK_W-1:0] outDataData,
    input  logic                  inCoreBusy,
    input  logic [GIFT_BLK_W-1:0] inCoreData,
    output logic                  outResValid,
    output logic [STREAM_W-1:0]   outResData,
    input  logic                  inResReady,
    output logic                  outBusy,
    output logic                  outErr
);
    localparam int CW = $clog2(WDOG_CYCLES > BUSY_RISE_WAIT ? WDOG_CYCLES : BUSY_RISE_WAIT) + 1;

    state_t                r_state;
    logic                  r_key_loaded;
    logic                  r_key_waiting;
    logic [CW-1:0]         r_cnt;
    logic [1:0]            r_idx;
    logic [GIFT_BLK_W-1:0] r_res;
    logic                  w_acc;
    logic                  w_key_we;
    logic                  w_ct_we;
    logic                  w_key_done;
    logic                  w_ct_done;
    logic                  w_ct_clr;
    logic                  w_wdog;

    assign outWordReady = r_state == LOAD;
    assign outKeyWr     = r_state == KEY;
    assign outDataWr    = r_state == DATA;
    assign outResValid  = r_state == OUT;
    assign outBusy      = r_state != LOAD;
    assign outResData   = r_res[{~r_idx, 5'd0} +: STREAM_W];

    // Ciphertext words arriving while a complete block waits for its key are dropped.
    assign w_acc    = inWordValid & outWordReady;
    assign w_key_we = w_acc & inWordSel;
    assign w_ct_we  = w_acc & ~inWordSel & ~r_key_waiting;
    assign w_ct_clr = (outResValid & inResReady & (&r_idx)) | w_wdog;

`ifdef GIFT_DEC_STREAM_WDOG_EN
    logic r_err;

    assign w_wdog = (r_state == WAIT_LO) & inCoreBusy & (r_cnt == CW'(WDOG_CYCLES - 1));

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) r_err <= 1'b0;
        else       r_err <= w_wdog;
    end

    assign outErr = r_err;
`else
    assign w_wdog = 1'b0;
    assign outErr = 1'b0;
`endif

    gift_word_packer u_key (
        .i_clk  (inClk),
        .i_rst  (inRst),
        .i_we   (w_key_we),
        .i_clr  (w_wdog),
        .i_data (inWordData),
        .o_blk  (outKeyData),
        .o_done (w_key_done)
    );

    gift_word_packer u_ct (
        .i_clk  (inClk),
        .i_rst  (inRst),
        .i_we   (w_ct_we),
        .i_clr  (w_ct_clr),
        .i_data (inWordData),
        .o_blk  (outDataData),
        .o_done (w_ct_done)
    );

    always_ff @(posedge inClk or posedge inRst) begin
        if (inRst) begin
            r_state       <= LOAD;
            r_key_loaded  <= 1'b0;
            r_key_waiting <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_res         <= '0;
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_key_done) begin
                        r_key_loaded <= 1'b1;
                        if (r_key_waiting) begin
                            r_key_waiting <= 1'b0;
                            r_state       <= KEY;
                        end
                    end else if (w_ct_done) begin
                        if (r_key_loaded) r_state       <= KEY;
                        else              r_key_waiting <= 1'b1;
                    end
                end
                KEY:  r_state <= DATA;
                DATA: begin
                    r_cnt   <= '0;
                    r_state <= WAIT_HI;
                end
                // Proceed even if busy never rises, so a fast core cannot stall the stream.
                WAIT_HI: begin
                    if (inCoreBusy || r_cnt == CW'(BUSY_RISE_WAIT - 1)) begin
                        r_cnt   <= '0;
                        r_state <= WAIT_LO;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!inCoreBusy) begin
                        r_res   <= inCoreData;
                        r_idx   <= '0;
                        r_state <= OUT;
                    end else if (w_wdog) begin
                        r_key_loaded  <= 1'b0;
                        r_key_waiting <= 1'b0;
                        r_state       <= LOAD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                OUT: begin
                    if (inResReady) begin
                        r_idx <= r_idx + 1'b1;
                        if (&r_idx) r_state <= LOAD;
                    end
                end
                default: r_state <= LOAD;
            endcase
        end
    end
endmodule

// File: tb/tb_gift_dec_stream_if.sv
// tb_gift_dec_stream_if: directed and randomized checks of the GIFT stream interface against a word-level model.
module tb_gift_dec_stream_if;
    logic         inClk = 1'b0;
    logic         inRst = 1'b1;
    logic         inWordValid = 1'b0;
    logic         inWordSel = 1'b0;
    logic [31:0]  inWordData = '0;
    logic         inCoreBusy = 1'b0;
    logic [127:0] inCoreData = '0;
    logic         inResReady = 1'b0;
    logic         outWordReady, outKeyWr, outDataWr, outResValid, outBusy, outErr;
    logic [127:0] outKeyData, outDataData;
    logic [31:0]  outResData;

    int total = 0;
    int bad = 0;
    logic [31:0] mk[4];
    logic [31:0] mc[4];
    int kc = 0;
    int cc = 0;
    bit kl = 0;
    bit kw = 0;

    gift_dec_stream_if dut (
        .inClk       (inClk),
        .inRst       (inRst),
        .inWordValid (inWordValid),
        .inWordSel   (inWordSel),
        .inWordData  (inWordData),
        .outWordReady(outWordReady),
        .outKeyWr    (outKeyWr),
        .outKeyData  (outKeyData),
        .outDataWr   (outDataWr),
        .outDataData (outDataData),
        .inCoreBusy  (inCoreBusy),
        .inCoreData  (inCoreData),
        .outResValid (outResValid),
        .outResData  (outResData),
        .inResReady  (inResReady),
        .outBusy     (outBusy),
        .outErr      (outErr)
    );

    always #5 inClk = ~inClk;

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    function automatic logic [127:0] cat(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c, input logic [31:0] d);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        kc = 0; cc = 0; kl = 0; kw = 0;
        for (int i = 0; i < 4; i++) begin
            mk[i] = '0;
            mc[i] = '0;
        end
    endtask

    // Drive one word, then check whether the model expects the key strobe on the following cycle.
    task automatic send(input bit sel, input logic [31:0] d);
        bit fire;
        fire = 0;
        @(negedge inClk);
        inWordValid = 1; inWordSel = sel; inWordData = d;
        @(negedge inClk);
        inWordValid = 0;
        if (sel) begin
            mk[kc] = d; kc = (kc + 1) % 4;
            if (kc == 0) begin kl = 1; fire = kw; kw = 0; end
        end else begin
            mc[cc] = d; cc = (cc + 1) % 4;
            if (cc == 0) begin fire = kl; kw = !kl; end
        end
        chk("strobe_ready", {outKeyWr, outWordReady}, {fire, !fire});
    endtask

    // Starts on the cycle outKeyWr is high; models the core and drains the four result words.
    task automatic run_block(input logic [127:0] cd, input int blen, input int mode);
        int k, n;
        bit r;
        k = 0; n = 0;
        inCoreData = cd;
        chk("key_data", outKeyData, cat(mk[0], mk[1], mk[2], mk[3]));
        chk("data_wr_early", outDataWr, 0);
        @(negedge inClk);
        chk("data_wr", {outKeyWr, outDataWr}, 2'b01);
        chk("ct_data", outDataData, cat(mc[0], mc[1], mc[2], mc[3]));
        @(negedge inClk);
        inCoreBusy = (blen > 0);
        for (int i = 0; i < blen; i++) begin
            @(negedge inClk);
            chk("busy_phase", {outWordReady, outResValid, outBusy, outDataWr, outKeyWr}, 5'b00100);
        end
        inCoreBusy = 0;
        while (k < 4 && n < 200) begin
            r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'(n % 2) : 1'($urandom_range(0, 1));
            inResReady = r;
            if (outResValid) begin
                chk("res_word", outResData, 32'(cd >> (32 * (3 - k))));
                if (r) k++;
            end
            n++;
            @(negedge inClk);
        end
        inResReady = 0;
        chk("handshakes", k, 4);
        chk("back_to_load", {outWordReady, outResValid, outBusy}, 3'b100);
    endtask

    initial begin
        int c;
        model_reset();
        repeat (2) @(negedge inClk);
        chk("reset_ctrl", {outWordReady, outBusy, outKeyWr, outDataWr, outResValid, outErr}, 6'b100000);
        chk("reset_key", outKeyData, 0);
        chk("reset_ct", outDataData, 0);
        inRst = 0;

        for (int i = 0; i < 4; i++) send(1, 32'h0);
        send(0, 32'h11111111);
        send(0, 32'h22222222);
        send(0, 32'h33333333);
        send(0, 32'h44444444);
        run_block({16{8'hA5}}, 40, 0);
        chk("tp_ct_const", outDataData, 128'h11111111222222223333333344444444);
        chk("tp_key_const", outKeyData, 0);

        // Second block reuses the stored key with a stalling sink.
        for (int i = 0; i < 4; i++) send(0, $urandom);
        run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 20), 1);

        // New key mid-stream, core that never raises busy.
        for (int i = 0; i < 4; i++) send(1, $urandom);
        for (int i = 0; i < 4; i++) send(0, $urandom);
        run_block({$urandom, $urandom, $urandom, $urandom}, 0, 2);

        // Reset while waiting for busy to fall.
        for (int i = 0; i < 4; i++) send(0, $urandom);
        @(negedge inClk);
        @(negedge inClk);
        inCoreBusy = 1;
        repeat (3) @(negedge inClk);
        chk("in_wait_lo", {outBusy, outWordReady}, 2'b10);
        #2 inRst = 1;
        #1 chk("reset_async", {outBusy, outResValid, outWordReady, outKeyWr, outDataWr}, 5'b00100);
        @(negedge inClk);
        inRst = 0;
        inCoreBusy = 0;
        model_reset();
        chk("reset_discard", outKeyData | outDataData, 0);

        // Ciphertext before key: strobe only after the fourth key word.
        for (int i = 0; i < 4; i++) send(0, $urandom);
        for (int i = 0; i < 4; i++) send(1, $urandom);
        run_block({$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 10), 2);

`ifdef GIFT_DEC_STREAM_WDOG_EN
        for (int i = 0; i < 4; i++) send(0, $urandom);
        @(negedge inClk);
        @(negedge inClk);
        inCoreBusy = 1;
        c = 0;
        while (!outErr && c < 300) begin
            @(negedge inClk);
            c++;
        end
        chk("wdog_cycle", c, 65);
        @(negedge inClk);
        chk("wdog_after", {outErr, outWordReady, outBusy}, 3'b010);
        inCoreBusy = 0;
        kl = 0; kc = 0; cc = 0; kw = 0;
        for (int i = 0; i < 4; i++) send(0, $urandom);
        for (int i = 0; i < 4; i++) send(1, $urandom);
        run_block({$urandom, $urandom, $urandom, $urandom}, 5, 0);
`else
        c = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge inClk);
            if (outErr !== 1'b0) c++;
        end
        chk("err_tied_low", c, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/gift_dec_stream_if.md
Name: gift_dec_stream_if

Overview:
- 32-bit streaming front/back end for the one-round GIFT-128 decryption core.
- Upstream side: assembles four 32-bit words into the 128-bit key and the 128-bit ciphertext, then pulses the core's key-write and data-write strobes.
- Downstream side: waits for the core to finish, captures its 128-bit plaintext and returns it as four 32-bit words on a valid/ready port.

Parameters:
- BUSY_RISE_WAIT, 4: max cycles after the data-write strobe for core busy to assert before the block proceeds anyway.
- WDOG_CYCLES, 64: watchdog limit on the busy-high phase; used only with the optional feature.

Ports:
- inClk  in  1  clock.
- inRst  in  1  asynchronous reset, active-high.
- inWordValid  in  1  input word present.
- inWordSel  in  1  1 = key word, 0 = ciphertext word.
- inWordData  in  32  input word.
- outWordReady  out  1  input word accepted when valid & ready.
- outKeyWr  out  1  one-cycle key-write strobe to core.
- outKeyData  out  128  assembled key.
- outDataWr  out  1  one-cycle data-write strobe to core.
- outDataData  out  128  assembled ciphertext.
- inCoreBusy  in  1  core busy.
- inCoreData  in  128  core result.
- outResValid  out  1  result word valid.
- outResData  out  32  result word.
- inResReady  in  1  sink accepts result word.
- outBusy  out  1  high in any state except LOAD.
- outErr  out  1  watchdog error pulse; tied 0 without the optional feature.

Behaviour:
- Reset values: all outputs 0; outWordReady = 1 after reset; state LOAD; word counters 0; keyLoaded = 0.
- Word order: first word goes to bits [127:96], fourth word to [31:0]. Separate 2-bit counters for key and ciphertext.
- A 4th key word sets keyLoaded = 1. A new key mid-stream overwrites word by word.
- LOAD: accept words while outWordReady = 1. outWordReady is 1 only in LOAD.
  - When the 4th ciphertext word is accepted and keyLoaded = 1, go to KEY.
  - If keyLoaded = 0, the ciphertext is held and keyWaiting is set. Completing the key then goes to KEY on the cycle after the 4th key word.
- KEY: outKeyWr = 1 for exactly one cycle -> DATA.
- DATA: outDataWr = 1 for exactly one cycle -> WAIT_HI. The key is rewritten before every block; the core consumes its key schedule.
- WAIT_HI: inCoreBusy = 1 -> WAIT_LO. If BUSY_RISE_WAIT cycles elapse without busy, also go to WAIT_LO.
- WAIT_LO: on the first cycle inCoreBusy = 0, capture inCoreData into the result register -> OUT, with index 0.
- OUT: outResValid = 1 and outResData = result word at the index (index 0 = [127:96]).
  - On valid & ready, increment the index.
  - The 4th handshake goes to LOAD with the ciphertext counter cleared; keyLoaded is kept.
  - outResData is stable while valid & !ready.
- Simultaneous events: inWordValid during non-LOAD states is ignored (not accepted). Key and data strobes are never asserted in the same cycle.
- Reset asserted in any state: immediate return to the reset values. Any partial words and the pending result are discarded.

Optional Feature:
- Macro GIFT_DEC_STREAM_WDOG_EN.
- Defined:
  - A counter runs in WAIT_LO.
  - Reaching WDOG_CYCLES with busy still high pulses outErr for 1 cycle and returns to LOAD without producing a result.
  - keyLoaded is cleared, forcing a key reload.
- Undefined: no counter; WAIT_LO waits indefinitely; outErr is constant 0.

Decomposition:
- Shared package (gift_pkg):
  - state encoding constants LOAD, KEY, DATA, WAIT_HI, WAIT_LO, OUT;
  - GIFT_BLK_W = 128;
  - STREAM_W = 32;
  - WORDS_PER_BLK = 4.
- One natural sub-module, gift_word_packer: 4x32 -> 128 shift/assemble register with counter and done flag. It is instantiated twice (key, ciphertext).
- Result unpacking is inline in the top.

Test Plan:
- Reset, then key words 0x00000000 x4 and ciphertext words 0x11111111, 0x22222222, 0x33333333, 0x44444444.
  - -> outKeyData = 0, outDataData = 0x11111111222222223333333344444444.
  - -> outKeyWr pulses 1 cycle, outDataWr pulses on the next cycle.
- Core model raises busy 1 cycle after outDataWr and holds it 40 cycles with inCoreData = 0xA5A5...A5.
  - -> four result words 0xA5A5A5A5 appear after busy falls; outWordReady = 0 throughout.
- Ciphertext sent before the key.
  - -> no strobes until the 4th key word; outKeyWr is asserted the next cycle.
- inResReady toggled 0/1 every cycle.
  - -> outResData is held while stalled; exactly 4 handshakes; return to LOAD.
- A second block without a new key.
  - -> the key is rewritten unchanged (outKeyWr pulses again).
- With GIFT_DEC_STREAM_WDOG_EN, busy stuck high.
  - -> outErr pulses at WDOG_CYCLES = 64; back to LOAD; keyLoaded = 0.
- Reset asserted in WAIT_LO.
  - -> outBusy = 0, outResValid = 0 immediately; outWordReady = 1.
